// File: rtl/load_store_unit_pkg.sv
// Shared LSU definitions: instruction IDs, FSM state encoding and decode helpers.
package load_store_unit_pkg;

   localparam logic [5:0] INSTR_ADD = 6'h00;
   localparam logic [5:0] INSTR_LB  = 6'h10;
   localparam logic [5:0] INSTR_LH  = 6'h11;
   localparam logic [5:0] INSTR_LW  = 6'h12;
   localparam logic [5:0] INSTR_LBU = 6'h13;
   localparam logic [5:0] INSTR_LHU = 6'h14;
   localparam logic [5:0] INSTR_SB  = 6'h18;
   localparam logic [5:0] INSTR_SH  = 6'h19;
   localparam logic [5:0] INSTR_SW  = 6'h1a;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_REQ,
      LSU_WAIT,
      LSU_DONE
   } lsu_state_e;

   function automatic logic is_load_op(input logic [5:0] id);
      return id inside {INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU};
   endfunction

   function automatic logic is_store_op(input logic [5:0] id);
      return id inside {INSTR_SB, INSTR_SH, INSTR_SW};
   endfunction

   function automatic logic is_mem_op(input logic [5:0] id);
      return is_load_op(id) || is_store_op(id);
   endfunction

   // Low address bits that are meaningful for the access size; the rest must be zero.
   function automatic logic [1:0] offset_mask(input logic [5:0] id);
      logic [1:0] m;
      case (id)
         INSTR_LB, INSTR_LBU, INSTR_SB: m = 2'b11;
         INSTR_LH, INSTR_LHU, INSTR_SH: m = 2'b10;
         default:                       m = 2'b00;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational load extraction: shifts the read word by the byte offset and extends it.
module load_align
   import load_store_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [5:0]  instr_id,
   output logic [31:0] data
);

   logic [31:0] shifted;

   assign shifted = rdata >> {offset, 3'b000};

   always_comb begin
      data = shifted;
      case (instr_id)
         INSTR_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
         INSTR_LBU: data = {24'h000000, shifted[7:0]};
         INSTR_LH:  data = {{16{shifted[15]}}, shifted[15:0]};
         INSTR_LHU: data = {16'h0000, shifted[15:0]};
         default:   data = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one word-aligned bus transaction per load or store.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses trap instead of being aligned down.
module load_store_unit
   import load_store_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [5:0]  instr_id,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd_addr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [31:0] load_data,
   output logic        load_data_valid,
   output logic [4:0]  load_rd_addr,
   output logic        stall_out,
   output logic        misaligned_out
);

   lsu_state_e  state_q, state_d;
   logic        accept;
   logic        trap;
   logic [1:0]  offset;
   logic [3:0]  wstrb_fmt;
   logic [31:0] wdata_fmt;
   logic [31:0] aligned_data;

   logic [5:0]  instr_q;
   logic [1:0]  offset_q;
   logic [4:0]  rd_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [31:0] load_data_q;
   logic        load_valid_q;
   logic [4:0]  load_rd_q;
   logic        mis_q;

   assign accept = (state_q == LSU_IDLE) && op_valid && is_mem_op(instr_id);
   // Offset is aligned down to the access size; only reachable misaligned in non-trap builds.
   assign offset = addr[1:0] & offset_mask(instr_id);

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = |(addr[1:0] & ~offset_mask(instr_id));
`else
   assign trap = 1'b0;
`endif

   always_comb begin
      wstrb_fmt = 4'b0000;
      wdata_fmt = 32'h0;
      case (instr_id)
         INSTR_SB: begin
            wstrb_fmt = 4'b0001 << offset;
            wdata_fmt = {4{store_data[7:0]}};
         end
         INSTR_SH: begin
            wstrb_fmt = offset[1] ? 4'b1100 : 4'b0011;
            wdata_fmt = {2{store_data[15:0]}};
         end
         INSTR_SW: begin
            wstrb_fmt = 4'b1111;
            wdata_fmt = store_data;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LSU_IDLE: if (accept) state_d = trap ? LSU_DONE : LSU_REQ;
         LSU_REQ:  if (mem_ready) state_d = is_load_op(instr_q) ? LSU_WAIT : LSU_DONE;
         LSU_WAIT: if (mem_rvalid) state_d = LSU_DONE;
         LSU_DONE: state_d = LSU_IDLE;
      endcase
   end

   load_align u_load_align (
      .rdata    (mem_rdata),
      .offset   (offset_q),
      .instr_id (instr_q),
      .data     (aligned_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= LSU_IDLE;
         instr_q      <= INSTR_ADD;
         offset_q     <= 2'b00;
         rd_q         <= 5'd0;
         we_q         <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         wstrb_q      <= 4'b0000;
         load_data_q  <= 32'h0;
         load_valid_q <= 1'b0;
         load_rd_q    <= 5'd0;
         mis_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_valid_q <= 1'b0;
         mis_q        <= 1'b0;
         if (accept) begin
            instr_q  <= instr_id;
            offset_q <= offset;
            rd_q     <= rd_addr;
            mis_q    <= trap;
            if (!trap) begin
               we_q    <= is_store_op(instr_id);
               addr_q  <= {addr[31:2], 2'b00};
               wdata_q <= wdata_fmt;
               wstrb_q <= wstrb_fmt;
            end
         end
         if (state_q == LSU_WAIT && mem_rvalid) begin
            load_data_q  <= aligned_data;
            load_rd_q    <= rd_q;
            load_valid_q <= 1'b1;
         end
      end
   end

   assign mem_req         = (state_q == LSU_REQ);
   assign mem_we          = we_q;
   assign mem_addr        = addr_q;
   assign mem_wdata       = wdata_q;
   assign mem_wstrb       = wstrb_q;
   assign load_data       = load_data_q;
   assign load_data_valid = load_valid_q;
   assign load_rd_addr    = load_rd_q;
   assign misaligned_out  = mis_q;
   assign stall_out       = accept || (state_q == LSU_REQ) || (state_q == LSU_WAIT);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset sequence, random ops.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        op_valid = 1'b0;
   logic [5:0]  instr_id = INSTR_ADD;
   logic [31:0] addr = 32'h0;
   logic [31:0] store_data = 32'h0;
   logic [4:0]  rd_addr = 5'd0;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic [31:0] load_data;
   logic        load_data_valid;
   logic [4:0]  load_rd_addr;
   logic        stall_out, misaligned_out;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk             (clk),
      .rst             (rst),
      .op_valid        (op_valid),
      .instr_id        (instr_id),
      .addr            (addr),
      .store_data      (store_data),
      .rd_addr         (rd_addr),
      .mem_req         (mem_req),
      .mem_we          (mem_we),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_wstrb       (mem_wstrb),
      .mem_ready       (mem_ready),
      .mem_rvalid      (mem_rvalid),
      .mem_rdata       (mem_rdata),
      .load_data       (load_data),
      .load_data_valid (load_data_valid),
      .load_rd_addr    (load_rd_addr),
      .stall_out       (stall_out),
      .misaligned_out  (misaligned_out)
   );

   typedef struct {
      logic [5:0]  instr;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] rdata;
      int          rwait;
      bit          exp_req;
      logic        exp_we;
      logic [31:0] exp_addr;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_wdata;
      logic [31:0] exp_load;
      int          exp_done;
      bit          exp_mis;
   } vec_t;

   typedef struct {
      logic        stall0;
      int          req_cycles;
      logic        we;
      logic [31:0] maddr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      bit          held;
      int          done;
      int          valid_cnt;
      int          valid_cyc;
      int          mis_cnt;
      int          mis_cyc;
      logic [31:0] ld;
      logic [4:0]  ld_rd;
   } obs_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_load = 32'h0;
   vec_t        tbl[$];
   logic [5:0]  ilist [9] = '{INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
                              INSTR_SB, INSTR_SH, INSTR_SW, INSTR_ADD};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [5:0] instr, input logic [31:0] a, sd, rdv,
                               input int rwait, input bit req, input logic we,
                               input logic [31:0] ma, input logic [3:0] ws,
                               input logic [31:0] wd, ld, input int done, input bit mis);
      vec_t v;
      v.instr = instr; v.addr = a; v.sdata = sd; v.rdata = rdv; v.rwait = rwait;
      v.exp_req = req; v.exp_we = we; v.exp_addr = ma; v.exp_wstrb = ws;
      v.exp_wdata = wd; v.exp_load = ld; v.exp_done = done; v.exp_mis = mis;
      return v;
   endfunction

   // Reference model: plain arithmetic on byte addresses and access sizes.
   function automatic vec_t model(input logic [5:0] instr, input logic [31:0] a, sd, rdv,
                                  input int rwait);
      vec_t v;
      int unsigned size;
      bit ld, st, sgn;
      longint unsigned aa, al, off, val, span;
      v = mk(instr, a, sd, rdv, rwait, 0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 0);
      ld  = instr inside {INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU};
      st  = instr inside {INSTR_SB, INSTR_SH, INSTR_SW};
      sgn = instr inside {INSTR_LB, INSTR_LH};
      if (instr inside {INSTR_LB, INSTR_LBU, INSTR_SB}) size = 1;
      else if (instr inside {INSTR_LH, INSTR_LHU, INSTR_SH}) size = 2;
      else if (instr inside {INSTR_LW, INSTR_SW}) size = 4;
      else size = 0;
      if (!(ld || st)) return v;
      aa = 64'(a);
`ifdef LSU_MISALIGN_TRAP_EN
      if (aa % size != 0) begin
         v.exp_mis = 1;
         return v;
      end
`endif
      al   = aa - aa % size;
      off  = al % 4;
      span = 64'd1 << (8 * size);
      v.exp_req  = 1;
      v.exp_we   = st;
      v.exp_addr = 32'(al - off);
      if (st) begin
         val = 64'(sd) % span;
         v.exp_wstrb = 4'(((64'd1 << size) - 1) << off);
         v.exp_wdata = (size == 1) ? 32'(val * 64'h01010101) :
                       (size == 2) ? 32'(val * 64'h00010001) : 32'(val);
         v.exp_done  = 2 + rwait;
      end else begin
         val = (64'(rdv) >> (8 * off)) % span;
         if (sgn && val >= span / 2) val = val + 64'h1_0000_0000 - span;
         v.exp_load = 32'(val);
         v.exp_done = 3 + rwait;
      end
      return v;
   endfunction

   task automatic run_op(input vec_t v, input logic [4:0] rd, output obs_t o);
      bit rv_given = 0;
      o = '{default: 0};
      o.done = -1;
      o.held = 1;
      @(negedge clk);
      op_valid = 1'b1; instr_id = v.instr; addr = v.addr; store_data = v.sdata;
      rd_addr = rd; mem_ready = 1'b0; mem_rvalid = 1'b0;
      #1;
      o.stall0 = stall_out;
      if (mem_req) o.req_cycles++;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         op_valid = 1'b0; addr = $urandom; mem_ready = 1'b0; mem_rvalid = 1'b0;
         #1;
         if (o.done < 0 && !stall_out) o.done = k;
         if (load_data_valid) begin
            o.valid_cnt++; o.valid_cyc = k; o.ld_rd = load_rd_addr;
         end
         if (misaligned_out) begin
            o.mis_cnt++; o.mis_cyc = k;
         end
         if (mem_req) begin
            if (o.req_cycles == 0) begin
               o.we = mem_we; o.maddr = mem_addr; o.wdata = mem_wdata; o.wstrb = mem_wstrb;
            end else if (mem_we !== o.we || mem_addr !== o.maddr || mem_wdata !== o.wdata ||
                         mem_wstrb !== o.wstrb || !stall_out) begin
               o.held = 0;
            end
            o.req_cycles++;
            if (o.req_cycles > v.rwait) mem_ready = 1'b1;
         end else if (stall_out && o.req_cycles > 0 && !rv_given) begin
            mem_rvalid = 1'b1; mem_rdata = v.rdata; rv_given = 1;
         end else if (o.done > 0 && k > o.done) begin
            mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
         end
      end
      o.ld = load_data;
      @(negedge clk);
      mem_ready = 1'b0; mem_rvalid = 1'b0;
   endtask

   task automatic check_op(input string tag, input vec_t v, input logic [4:0] rd,
                           input obs_t o);
      bit is_ld, is_st;
      is_ld = v.instr inside {INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU};
      is_st = v.instr inside {INSTR_SB, INSTR_SH, INSTR_SW};
      chk({tag, " stall_accept"}, 32'(o.stall0), 32'(is_ld || is_st));
      chk({tag, " req_cycles"}, 32'(o.req_cycles), v.exp_req ? 32'(v.rwait + 1) : 32'd0);
      if (v.exp_req) begin
         chk({tag, " mem_we"}, 32'(o.we), 32'(v.exp_we));
         chk({tag, " mem_addr"}, o.maddr, v.exp_addr);
         chk({tag, " held"}, 32'(o.held), 32'd1);
         if (is_st) begin
            chk({tag, " mem_wstrb"}, 32'(o.wstrb), 32'(v.exp_wstrb));
            chk({tag, " mem_wdata"}, o.wdata, v.exp_wdata);
         end
      end
      chk({tag, " done_cycle"}, 32'(o.done), 32'(v.exp_done));
      if (is_ld && v.exp_req) begin
         last_load = v.exp_load;
         chk({tag, " valid_cnt"}, 32'(o.valid_cnt), 32'd1);
         chk({tag, " valid_cycle"}, 32'(o.valid_cyc), 32'(v.exp_done));
         chk({tag, " load_rd_addr"}, 32'(o.ld_rd), 32'(rd));
      end else begin
         chk({tag, " valid_cnt"}, 32'(o.valid_cnt), 32'd0);
      end
      chk({tag, " load_data"}, o.ld, last_load);
      chk({tag, " mis_cnt"}, 32'(o.mis_cnt), 32'(v.exp_mis));
      if (v.exp_mis) chk({tag, " mis_cycle"}, 32'(o.mis_cyc), 32'd1);
   endtask

   initial begin
      obs_t o;
      vec_t v;
      int   vcnt;

      #1 rst = 1'b1;
      #1;
      chk("rst mem_req", 32'(mem_req), 32'd0);
      chk("rst mem_we", 32'(mem_we), 32'd0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst mem_wdata", mem_wdata, 32'h0);
      chk("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
      chk("rst load_data", load_data, 32'h0);
      chk("rst load_data_valid", 32'(load_data_valid), 32'd0);
      chk("rst load_rd_addr", 32'(load_rd_addr), 32'd0);
      chk("rst misaligned_out", 32'(misaligned_out), 32'd0);
      chk("rst stall_out", 32'(stall_out), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset while waiting for read data: the late rvalid must be ignored.
      @(negedge clk);
      op_valid = 1'b1; instr_id = INSTR_LW; addr = 32'h500; rd_addr = 5'd7;
      @(negedge clk);
      op_valid = 1'b0; #1;
      chk("rstwait mem_req", 32'(mem_req), 32'd1);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0; #1;
      chk("rstwait in_wait", 32'({stall_out, mem_req}), 32'b10);
      rst = 1'b1; #1;
      chk("rstwait stall_after_rst", 32'(stall_out), 32'd0);
      #1 rst = 1'b0;
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      mem_rvalid = 1'b0;
      vcnt = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         if (load_data_valid || mem_req || stall_out) vcnt++;
         @(negedge clk);
      end
      chk("rstwait activity", 32'(vcnt), 32'd0);
      chk("rstwait load_data", load_data, 32'h0);

      tbl.push_back(mk(INSTR_LB, 32'h103, 32'h0, 32'h80000000, 0,
                       1, 1'b0, 32'h100, 4'h0, 32'h0, 32'hFFFFFF80, 3, 0));
      tbl.push_back(mk(INSTR_LBU, 32'h103, 32'h0, 32'h80000000, 0,
                       1, 1'b0, 32'h100, 4'h0, 32'h0, 32'h00000080, 3, 0));
      tbl.push_back(mk(INSTR_SH, 32'h202, 32'h1234ABCD, 32'h0, 0,
                       1, 1'b1, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0, 2, 0));
      tbl.push_back(mk(INSTR_LW, 32'h40, 32'h0, 32'hCAFEF00D, 3,
                       1, 1'b0, 32'h40, 4'h0, 32'h0, 32'hCAFEF00D, 6, 0));
`ifdef LSU_MISALIGN_TRAP_EN
      tbl.push_back(mk(INSTR_LW, 32'h101, 32'h0, 32'h11223344, 0,
                       0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 1));
`else
      tbl.push_back(mk(INSTR_LW, 32'h101, 32'h0, 32'h11223344, 0,
                       1, 1'b0, 32'h100, 4'h0, 32'h0, 32'h11223344, 3, 0));
`endif
      tbl.push_back(mk(INSTR_ADD, 32'h104, 32'h0, 32'h0, 0,
                       0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 0));
      tbl.push_back(mk(INSTR_SB, 32'h3001, 32'h000000A5, 32'h0, 1,
                       1, 1'b1, 32'h3000, 4'b0010, 32'hA5A5A5A5, 32'h0, 3, 0));
      tbl.push_back(mk(INSTR_LHU, 32'h2, 32'h0, 32'h80010000, 0,
                       1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h00008001, 3, 0));
      tbl.push_back(mk(INSTR_LH, 32'h2, 32'h0, 32'h80010000, 2,
                       1, 1'b0, 32'h0, 4'h0, 32'h0, 32'hFFFF8001, 5, 0));
      tbl.push_back(mk(INSTR_SW, 32'h7C, 32'h89ABCDEF, 32'h0, 0,
                       1, 1'b1, 32'h7C, 4'b1111, 32'h89ABCDEF, 32'h0, 2, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         run_op(tbl[i], 5'(i + 1), o);
         check_op($sformatf("vec%0d", i), tbl[i], 5'(i + 1), o);
      end

      for (int i = 0; i < 80; i++) begin
         logic [4:0] rd;
         rd = 5'($urandom_range(0, 31));
         v = model(ilist[$urandom_range(0, 8)], $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)));
         run_op(v, rd, o);
         check_op($sformatf("rnd%0d", i), v, rd, o);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
